mem_dump_ctrl: RTL and testbench

- Debug-side initiator for the data-memory debug read port.
- On a start request it takes ownership of the memory through debug_on, then sweeps a contiguous word range with debug_addr.
- It captures each returned word and streams it as bytes over a valid/ready handshake to the UART transmitter.
- Sits between the debug unit's command decoder and the UART TX; the pipeline is frozen while debug_on is high.

---
 rtl/mem_dump_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// ----------------------------------------------------------------------------
// mem_dump_ctrl
//
// Debug-side initiator for the data-memory debug read port. A start request
// takes ownership of the memory (debug_on), sweeps WORDS consecutive word
// addresses beginning at start_addr, captures each returned word and streams
// it to the UART transmitter as four bytes over a valid/ready handshake.
//
// Handshake: a byte moves on a rising clk edge where tx_valid and tx_ready
// are both high. While tx_valid=1 and tx_ready=0, tx_data is held unchanged
// for as long as the stall lasts. tx_valid is only ever high in SEND.
//
// Parameters:
//   WORDS      number of consecutive words dumped per start (>= 1)
//   MSB_FIRST  1: bits 31:24 go out first, 0: bits 7:0 go out first
//
// Ports:
//   clk             system clock, all state on posedge
//   rst             asynchronous, active-high reset
//   start           one-cycle dump request, honoured only in IDLE
//   start_addr      first word address, sampled with an accepted start
//   debug_on        memory debug-mode enable (memory owned by this block)
//   debug_addr      word address to the memory debug read port
//   mem_debug_data  registered read data, memory updates it on negedge
//   tx_data         byte to the UART TX
//   tx_valid        tx_data is valid
//   tx_ready        UART TX accepts the byte this cycle
//   busy            high from the accepted start until done
//   done            one-cycle pulse after the last byte is accepted
// ----------------------------------------------------------------------------
module mem_dump_ctrl #(
    parameter int unsigned WORDS     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic        debug_on,
    output logic [31:0] debug_addr,
    input  logic [31:0] mem_debug_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [31:0] LAST_WORD = 32'(WORDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_word_cnt;
    logic [31:0] r_capture;
    logic [1:0]  r_byte_idx;

    // Datapath strobes produced by the next-state logic.
    logic        w_load_start;
    logic        w_advance;
    logic        w_capture_en;
    logic        w_byte_xfer;

    logic [1:0]  w_lane;
    logic [7:0]  w_sel_byte;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_load_start = 1'b0;
        w_advance    = 1'b0;
        w_capture_en = 1'b0;
        w_byte_xfer  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Address is already stable; the memory registers it on
                // the coming negedge.
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture_en = 1'b1;
                w_state_nxt  = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_byte_xfer = 1'b1;
                    if (r_byte_idx == 2'd3) begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (r_word_cnt == LAST_WORD) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DONE: begin
                // A start seen here is deliberately dropped.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address, word counter, capture register, byte index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= 32'd0;
            r_word_cnt <= 32'd0;
            r_capture  <= 32'd0;
            r_byte_idx <= 2'd0;
        end else begin
            if (w_load_start) begin
                r_addr     <= start_addr;
                r_word_cnt <= 32'd0;
            end
            if (w_advance) begin
                // 32-bit modulo: 0xFFFFFFFF rolls over to 0.
                r_addr     <= r_addr + 32'd1;
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_capture_en) begin
                r_capture  <= mem_debug_data;
                r_byte_idx <= 2'd0;
            end
            if (w_byte_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte selection. With MSB_FIRST the lane runs 3,2,1,0, which for a
    // two-bit index is simply its inversion.
    // ------------------------------------------------------------------
    assign w_lane = MSB_FIRST ? ~r_byte_idx : r_byte_idx;

    always_comb begin
        w_sel_byte = 8'd0;
        case (w_lane)
            2'd0:    w_sel_byte = r_capture[7:0];
            2'd1:    w_sel_byte = r_capture[15:8];
            2'd2:    w_sel_byte = r_capture[23:16];
            default: w_sel_byte = r_capture[31:24];
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the state register so that an asynchronous
    // reset drops them in the same cycle, with no partial done pulse.
    // ------------------------------------------------------------------
    always_comb begin
        debug_on = 1'b0;
        busy     = 1'b0;
        tx_valid = 1'b0;
        done     = 1'b0;
        tx_data  = 8'd0;

        case (r_state)
            S_ISSUE, S_WAIT, S_CAPTURE, S_NEXT: begin
                debug_on = 1'b1;
                busy     = 1'b1;
            end
            S_SEND: begin
                debug_on = 1'b1;
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = w_sel_byte;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                debug_on = 1'b0;
            end
        endcase
    end

    assign debug_addr = r_addr;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_dump_ctrl
//
// Two instances share clock, reset and tx_ready: u_dut0 (WORDS=2, MSB first)
// and u_dut1 (WORDS=1, LSB first). Only one instance is dumping at a time;
// "sel" names the active one. Expected bytes and debug addresses come from
// a reference memory function and plain shift arithmetic, pushed into
// queues when a dump is requested. A negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_mem_dump_ctrl;

    localparam int W0 = 2;
    localparam int W1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start0, start1;
    logic [31:0] start_addr;
    logic        tx_ready;
    logic [31:0] mdata0 = '0;
    logic [31:0] mdata1 = '0;
    logic        debug_on0, debug_on1;
    logic [31:0] debug_addr0, debug_addr1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        busy0, busy1;
    logic        done0, done1;

    mem_dump_ctrl #(.WORDS(W0), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .start_addr(start_addr),
        .debug_on(debug_on0), .debug_addr(debug_addr0), .mem_debug_data(mdata0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .done(done0)
    );

    mem_dump_ctrl #(.WORDS(W1), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .start_addr(start_addr),
        .debug_on(debug_on1), .debug_addr(debug_addr1), .mem_debug_data(mdata1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .done(done1)
    );

    // ---------------- reference memory ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd5) return 32'h12345678;
        return 32'hA0B0C0D0 + a;
    endfunction

    // Registered debug read port, updated on negedge while owned.
    always @(negedge clk) begin
        if (debug_on0) mdata0 <= mem_word(debug_addr0);
        if (debug_on1) mdata1 <= mem_word(debug_addr1);
    end

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    int          sel = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] exp_addr_q[$];
    bit          hold_pending = 0;
    logic [7:0]  hold_data = '0;
    int          bytes_in_dump = 0;
    int          done_cnt = 0;
    bit          prev_on = 0;
    logic [31:0] prev_addr = '0;
    int          ready_mode = 0;
    int          stall_cnt = 0;
    bit          stall_done = 0;

    wire        w_valid = (sel != 0) ? tx_valid1   : tx_valid0;
    wire [7:0]  w_data  = (sel != 0) ? tx_data1    : tx_data0;
    wire        w_on    = (sel != 0) ? debug_on1   : debug_on0;
    wire [31:0] w_addr  = (sel != 0) ? debug_addr1 : debug_addr0;
    wire        w_busy  = (sel != 0) ? busy1       : busy0;
    wire        w_done  = (sel != 0) ? done1       : done0;
    wire        w_other = (sel != 0) ? (tx_valid0 | debug_on0 | busy0)
                                     : (tx_valid1 | debug_on1 | busy1);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
            prev_on      = 0;
        end else begin
            if (done0 || done1) done_cnt++;
            check("other_inst_idle", {63'd0, w_other}, 64'd0);
            if (hold_pending) begin
                check("stall_valid_held", {63'd0, w_valid}, 64'd1);
                check("stall_data_held", {56'd0, w_data}, {56'd0, hold_data});
            end
            hold_pending = w_valid && !tx_ready;
            hold_data    = w_data;
            if (w_valid && tx_ready) begin
                if (exp_q.size() == 0) fail("extra_byte");
                else check("tx_byte", {56'd0, w_data}, {56'd0, exp_q.pop_front()});
                bytes_in_dump++;
            end
            if (w_on && (!prev_on || w_addr != prev_addr)) begin
                if (exp_addr_q.size() == 0) fail("extra_debug_addr");
                else check("debug_addr", {32'd0, w_addr}, {32'd0, exp_addr_q.pop_front()});
            end
            prev_on   = w_on;
            prev_addr = w_addr;
        end
    end

    // ---------------- tx_ready driver ----------------
    // mode 0: tied high; mode 1: random; mode 2: ten-cycle stall on byte 2.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: tx_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stall_done && w_valid && bytes_in_dump == 2) begin
                        stall_cnt  = 10;
                        stall_done = 1;
                    end
                    if (stall_cnt > 0) begin
                        tx_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_start(input int inst, input logic v);
        if (inst != 0) start1 = v;
        else           start0 = v;
    endtask

    task automatic push_expect(input int inst, input logic [31:0] addr);
        int          words;
        logic [31:0] wd;
        logic [31:0] a;
        words = (inst != 0) ? W1 : W0;
        for (int w = 0; w < words; w++) begin
            a  = addr + w;
            wd = mem_word(a);
            exp_addr_q.push_back(a);
            for (int k = 0; k < 4; k++) begin
                // inst 0 sends the most significant byte first.
                if (inst == 0) exp_q.push_back(8'((wd >> (8 * (3 - k))) & 32'hFF));
                else           exp_q.push_back(8'((wd >> (8 * k)) & 32'hFF));
            end
        end
    endtask

    task automatic flush_sb();
        exp_q.delete();
        exp_addr_q.delete();
        hold_pending  = 0;
        bytes_in_dump = 0;
    endtask

    task automatic pulse_start(input int inst, input logic [31:0] addr);
        @(negedge clk);
        start_addr = addr;
        set_start(inst, 1'b1);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);
        start_addr = $urandom;
    endtask

    task automatic run_dump(input int inst, input logic [31:0] addr, input int mode,
                            input bit mid_start, input bit done_start);
        int words;
        int n;
        bit gap;
        int done_before;
        words = (inst != 0) ? W1 : W0;
        sel = inst;
        ready_mode = mode;
        stall_done = 0;
        stall_cnt = 0;
        flush_sb();
        push_expect(inst, addr);
        done_before = done_cnt;
        pulse_start(inst, addr);
        n = 0;
        gap = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (w_done) break;
            if (!w_on || !w_busy) gap = 1;
            if (mid_start && n == 5) begin
                start_addr = $urandom;
                set_start(inst, 1'b1);
            end
            if (mid_start && n == 6) set_start(inst, 1'b0);
            if (n > 4000) begin
                fail("done_timeout");
                set_start(inst, 1'b0);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                flush_sb();
                ready_mode = 0;
                return;
            end
        end
        set_start(inst, 1'b0);
        check("on_busy_span_no_gap", {63'd0, gap}, 64'd0);
        check("done_cycle_outputs", {61'd0, w_on, w_busy, w_valid}, 64'd0);
        if (mode == 0) check("dump_cycles", 64'(n), 64'(8 * words));
        if (done_start) begin
            start_addr = $urandom;
            set_start(inst, 1'b1);
        end
        @(negedge clk);
        set_start(inst, 1'b0);
        check("after_done_idle", {61'd0, w_done, w_busy, w_on}, 64'd0);
        repeat (3) @(negedge clk);
        check("stays_idle", {62'd0, w_busy, w_on}, 64'd0);
        check("done_pulses", 64'(done_cnt - done_before), 64'd1);
        check("bytes_left", 64'(exp_q.size()), 64'd0);
        check("addrs_left", 64'(exp_addr_q.size()), 64'd0);
        check("byte_count", 64'(bytes_in_dump), 64'(4 * words));
        ready_mode = 0;
    endtask

    task automatic reset_mid_send(input logic [31:0] addr);
        int n;
        int done_before;
        sel = 0;
        ready_mode = 0;
        flush_sb();
        push_expect(0, addr);
        done_before = done_cnt;
        pulse_start(0, addr);
        n = 0;
        while (bytes_in_dump < 5 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) fail("reach_word1_send");
        check("pre_reset_in_send", {63'd0, tx_valid0}, 64'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {20'd0, debug_on0, tx_valid0, busy0, done0, tx_data0, debug_addr0}, 64'd0);
        flush_sb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt - done_before), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        int          inst;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start_addr = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut0",
              {20'd0, debug_on0, tx_valid0, busy0, done0, tx_data0, debug_addr0}, 64'd0);
        check("reset_outputs_dut1",
              {20'd0, debug_on1, tx_valid1, busy1, done1, tx_data1, debug_addr1}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two words from address 0, MSB first, no back-pressure.
        run_dump(0, 32'd0, 0, 0, 0);
        // One word 0x12345678 at address 5, LSB first.
        run_dump(1, 32'd5, 0, 0, 0);
        // Ten-cycle stall on byte 2.
        run_dump(0, 32'd40, 2, 0, 0);
        // Second start while busy is dropped.
        run_dump(0, $urandom, 1, 1, 0);
        // Address wrap.
        run_dump(0, 32'hFFFFFFFF, 0, 0, 0);
        // Start in the DONE cycle is dropped.
        run_dump(0, 32'd100, 0, 0, 1);
        // Reset during SEND of the second word, then a clean dump.
        reset_mid_send(32'd200);
        run_dump(0, 32'd300, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            inst = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 1));
            run_dump(inst, a, $urandom_range(0, 2), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
